// File: rtl/wash_pkg.sv
// Shared types and helpers for the wash phase timer.
package wash_pkg;

  typedef enum logic [1:0] {
    PH_FILL  = 2'b00,
    PH_WASH  = 2'b01,
    PH_RINSE = 2'b10,
    PH_SPIN  = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  localparam int unsigned SEC_W = 10;

  // Phase length in seconds; wash and rinse double when requested, spin never does.
  function automatic logic [SEC_W-1:0] phase_secs(
    input phase_t      ph,
    input logic        dbl,
    input int unsigned fill_s,
    input int unsigned wash_s,
    input int unsigned rinse_s,
    input int unsigned spin_s
  );
    logic [SEC_W-1:0] secs;
    case (ph)
      PH_FILL:  secs = SEC_W'(fill_s);
      PH_WASH:  secs = dbl ? SEC_W'(wash_s * 2)  : SEC_W'(wash_s);
      PH_RINSE: secs = dbl ? SEC_W'(rinse_s * 2) : SEC_W'(rinse_s);
      default:  secs = SEC_W'(spin_s);
    endcase
    return secs;
  endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// Loadable, holdable prescaler: emits a one-cycle sec_tick every reload+1 enabled cycles.
module wash_tick_gen
  import wash_pkg::*;
#(
  parameter int unsigned PW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  input  logic          clear,
  input  logic          en,
  output logic          sec_tick
);

  logic [PW-1:0] cnt;
  logic [PW-1:0] rld;

  assign sec_tick = en && (cnt == '0);

  // Count down while enabled, reloading from the latched period when the count hits zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      rld <= '0;
    end else if (load) begin
      cnt <= load_val;
      rld <= load_val;
    end else if (clear) begin
      cnt <= '0;
      rld <= '0;
    end else if (en) begin
      cnt <= (cnt == '0) ? rld : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/wash_phase_timer.sv
// Phase-duration responder: counts seconds of the requested phase and pulses timer_finish.
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int unsigned BASE_TICKS = 1_000_000,
  parameter int unsigned FILL_S     = 120,
  parameter int unsigned WASH_S     = 300,
  parameter int unsigned RINSE_S    = 120,
  parameter int unsigned SPIN_S     = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       clk_freq,
  input  logic             phase_start,
  input  logic [1:0]       phase_sel,
  input  logic             double_time,
  input  logic             timer_pause,
  input  logic             phase_abort,
  output logic             timer_finish,
  output logic             busy,
  output logic             start_err,
  output logic [SEC_W-1:0] remaining_sec
);

  localparam int unsigned PW = $clog2(BASE_TICKS * 8);

  state_t           state;
  logic [SEC_W-1:0] sec;
  logic [PW:0]      ticks;
  logic [PW-1:0]    presc_load;
  logic [SEC_W-1:0] start_secs;
  logic             accept;
  logic             active;
  logic             sec_tick;

  assign active        = (state == ST_RUN) || (state == ST_PAUSED);
  assign busy          = active;
  assign accept        = phase_start && !active;
  assign remaining_sec = sec;
  assign start_secs    = phase_secs(phase_t'(phase_sel), double_time,
                                    FILL_S, WASH_S, RINSE_S, SPIN_S);

  // Prescaler period for the requested tick rate.
  always_comb begin
    ticks      = (PW + 1)'(BASE_TICKS) << clk_freq;
    presc_load = PW'(ticks - 1'b1);
  end

  // Counting continues in the PAUSED->RUN cycle so a pause of N cycles delays finish by exactly N.
  wash_tick_gen #(.PW(PW)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (presc_load),
    .clear    (active && phase_abort),
    .en       (active && !timer_pause && !phase_abort),
    .sec_tick (sec_tick)
  );

  // Phase FSM and seconds counter with registered finish/error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      sec          <= '0;
      timer_finish <= 1'b0;
      start_err    <= 1'b0;
    end else begin
      timer_finish <= 1'b0;
      start_err    <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (phase_start) begin
            sec   <= start_secs;
            state <= ST_RUN;
          end else begin
            sec   <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          if (phase_abort) begin
            sec   <= '0;
            state <= ST_IDLE;
          end else begin
            start_err <= phase_start;
            if (timer_pause) begin
              state <= ST_PAUSED;
            end else if (sec_tick) begin
              if (sec == SEC_W'(1)) begin
                sec          <= '0;
                state        <= ST_DONE;
                timer_finish <= 1'b1;
              end else begin
                sec   <= sec - 1'b1;
                state <= ST_RUN;
              end
            end else begin
              state <= ST_RUN;
            end
          end
        end
      endcase
    end
  end

endmodule
